// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shared I/D-cache miss engine. Arbitrates I-misses,
// D-misses and D write-through stores onto one pipelined fixed-latency
// memory port, streams block fills back into the requesting cache and
// produces per-cache stall / completion signals.
module cache_fill_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WORD_BYTES  = 2,
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_miss,
    input  logic [ADDR_W-1:0]              i_miss_addr,
    input  logic                           d_miss,
    input  logic                           d_wr,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic [DATA_W-1:0]              d_wdata,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_valid,
    output logic                           fill_we_i,
    output logic                           fill_we_d,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]              fill_data,
    output logic [ADDR_W-1:0]              fill_base,
    output logic                           tag_we_i,
    output logic                           tag_we_d,
    output logic                           i_done,
    output logic                           d_done,
    output logic                           i_stall,
    output logic                           d_stall,
    output logic                           busy
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int WB_SH = $clog2(WORD_BYTES);
    localparam int DRN_W = $clog2(MEM_LATENCY + 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(BLOCK_WORDS * WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] WRD_MASK = ~ADDR_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0]  NWORDS   = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL_I, S_FILL_D, S_WRITE, S_DONE_I, S_DONE_D
    } state_t;

    typedef struct packed {
        logic              en;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  iss, ret;
    logic [DRN_W-1:0]  drain;
    logic [ADDR_W-1:0] base_q, wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    mem_req_t          mreq;

    logic in_fill, issue, ret_strobe, ret_last;

    // Fill-phase qualifiers; late returns past the block end are dropped.
    always_comb begin
        in_fill    = (state == S_FILL_I) || (state == S_FILL_D);
        issue      = in_fill && (iss < NWORDS);
        ret_strobe = rst && in_fill && mem_valid && (ret < NWORDS);
        ret_last   = ret_strobe && (ret == LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next state: stores beat misses, D beats I; nothing accepted while draining.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (drain == '0) begin
                    if (d_wr)        state_nxt = S_WRITE;
                    else if (d_miss) state_nxt = S_FILL_D;
                    else if (i_miss) state_nxt = S_FILL_I;
                end
            end
            S_FILL_I: if (ret_last) state_nxt = S_DONE_I;
            S_FILL_D: if (ret_last) state_nxt = S_DONE_D;
            S_WRITE:  state_nxt = S_DONE_D;
            S_DONE_I: state_nxt = S_IDLE;
            S_DONE_D: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Counters, reset drain and request capture. The drain holds off new
    // fills long enough for returns of a reset-aborted fill to flush out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            iss       <= '0;
            ret       <= '0;
            drain     <= DRN_W'(MEM_LATENCY);
            base_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (drain != '0) drain <= drain - DRN_W'(1);
            if (state == S_IDLE) begin
                iss <= '0;
                ret <= '0;
                case (state_nxt)
                    S_WRITE: begin
                        wr_addr_q <= d_addr & WRD_MASK;
                        wr_data_q <= d_wdata;
                    end
                    S_FILL_D: base_q <= d_addr & BLK_MASK;
                    S_FILL_I: base_q <= i_miss_addr & BLK_MASK;
                    default: ;
                endcase
            end else begin
                if (issue)      iss <= iss + CNT_W'(1);
                if (ret_strobe) ret <= ret + CNT_W'(1);
            end
        end
    end

    // Outputs: decoded from state; everything but busy is forced low in reset.
    always_comb begin
        mreq      = '0;
        fill_we_i = 1'b0;
        fill_we_d = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
        fill_base = '0;
        tag_we_i  = 1'b0;
        tag_we_d  = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        i_stall   = 1'b0;
        d_stall   = 1'b0;
        busy      = !rst || (state != S_IDLE) || (drain != '0);
        if (rst) begin
            case (state)
                S_FILL_I, S_FILL_D: begin
                    mreq.en   = issue;
                    mreq.addr = issue ? base_q + (ADDR_W'(iss) << WB_SH) : '0;
                    fill_we_i = ret_strobe && (state == S_FILL_I);
                    fill_we_d = ret_strobe && (state == S_FILL_D);
                    tag_we_i  = ret_last && (state == S_FILL_I);
                    tag_we_d  = ret_last && (state == S_FILL_D);
                end
                S_WRITE: begin
                    mreq.en    = 1'b1;
                    mreq.wr    = 1'b1;
                    mreq.addr  = wr_addr_q;
                    mreq.wdata = wr_data_q;
                end
                S_DONE_I: i_done = 1'b1;
                S_DONE_D: d_done = 1'b1;
                default: ;
            endcase
            if (ret_strobe) begin
                fill_idx  = ret[IDX_W-1:0];
                fill_data = mem_rdata;
            end
            fill_base = base_q;
            i_stall   = i_miss && !i_done;
            d_stall   = (d_miss || d_wr) && !d_done;
        end
        mem_en    = mreq.en;
        mem_wr    = mreq.wr;
        mem_addr  = mreq.addr;
        mem_wdata = mreq.wdata;
    end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: three instances (default, BW=2/L=1,
// BW=16/L=7) against a fixed-latency memory model; expectations come from
// the timing rules relative to the acceptance cycle.
module tb_cache_fill_arbiter;
    localparam int N = 3;

    function automatic int bw_of(input int n);
        return (n == 0) ? 8 : (n == 1) ? 2 : 16;
    endfunction
    function automatic int lat_of(input int n);
        return (n == 0) ? 4 : (n == 1) ? 1 : 7;
    endfunction
    function automatic logic [15:0] blk_base(input int n, input logic [15:0] a);
        return a & ~16'(bw_of(n) * 2 - 1);
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        im [N], dm [N], dw [N];
    logic [15:0] iaddr [N], daddr [N], dwd [N];
    logic        men [N], mwr [N], mval [N], fwi [N], fwd [N];
    logic        twi [N], twd [N], idn [N], ddn [N], ist [N], dst [N], bsy [N];
    logic [15:0] maddr [N], mwd [N], mrd [N], fdat [N], fbase [N], fidx [N];
    logic [15:0] pat [N];
    logic [2:0]  fidx0;
    logic [0:0]  fidx1;
    logic [3:0]  fidx2;
    assign fidx[0] = 16'(fidx0);
    assign fidx[1] = 16'(fidx1);
    assign fidx[2] = 16'(fidx2);

    cache_fill_arbiter #(.BLOCK_WORDS(8), .MEM_LATENCY(4)) u0 (
        .clk(clk), .rst(rst), .i_miss(im[0]), .i_miss_addr(iaddr[0]),
        .d_miss(dm[0]), .d_wr(dw[0]), .d_addr(daddr[0]), .d_wdata(dwd[0]),
        .mem_en(men[0]), .mem_wr(mwr[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
        .mem_rdata(mrd[0]), .mem_valid(mval[0]), .fill_we_i(fwi[0]), .fill_we_d(fwd[0]),
        .fill_idx(fidx0), .fill_data(fdat[0]), .fill_base(fbase[0]),
        .tag_we_i(twi[0]), .tag_we_d(twd[0]), .i_done(idn[0]), .d_done(ddn[0]),
        .i_stall(ist[0]), .d_stall(dst[0]), .busy(bsy[0]));

    cache_fill_arbiter #(.BLOCK_WORDS(2), .MEM_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .i_miss(im[1]), .i_miss_addr(iaddr[1]),
        .d_miss(dm[1]), .d_wr(dw[1]), .d_addr(daddr[1]), .d_wdata(dwd[1]),
        .mem_en(men[1]), .mem_wr(mwr[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
        .mem_rdata(mrd[1]), .mem_valid(mval[1]), .fill_we_i(fwi[1]), .fill_we_d(fwd[1]),
        .fill_idx(fidx1), .fill_data(fdat[1]), .fill_base(fbase[1]),
        .tag_we_i(twi[1]), .tag_we_d(twd[1]), .i_done(idn[1]), .d_done(ddn[1]),
        .i_stall(ist[1]), .d_stall(dst[1]), .busy(bsy[1]));

    cache_fill_arbiter #(.BLOCK_WORDS(16), .MEM_LATENCY(7)) u2 (
        .clk(clk), .rst(rst), .i_miss(im[2]), .i_miss_addr(iaddr[2]),
        .d_miss(dm[2]), .d_wr(dw[2]), .d_addr(daddr[2]), .d_wdata(dwd[2]),
        .mem_en(men[2]), .mem_wr(mwr[2]), .mem_addr(maddr[2]), .mem_wdata(mwd[2]),
        .mem_rdata(mrd[2]), .mem_valid(mval[2]), .fill_we_i(fwi[2]), .fill_we_d(fwd[2]),
        .fill_idx(fidx2), .fill_data(fdat[2]), .fill_base(fbase[2]),
        .tag_we_i(twi[2]), .tag_we_d(twd[2]), .i_done(idn[2]), .d_done(ddn[2]),
        .i_stall(ist[2]), .d_stall(dst[2]), .busy(bsy[2]));

    // Memory model: a read issued in cycle t returns in cycle t+latency with
    // data pat + word-index-in-block. Not reset, so aborted fills leave stale returns.
    logic [7:0]  pv [N] = '{8'd0, 8'd0, 8'd0};
    logic [15:0] pa [N][8];
    always @(posedge clk) begin
        for (int n = 0; n < N; n++) begin
            pv[n] <= {pv[n][6:0], men[n] & ~mwr[n]};
            for (int i = 7; i > 0; i--) pa[n][i] <= pa[n][i-1];
            pa[n][0] <= maddr[n];
        end
    end
    for (genvar g = 0; g < N; g++) begin : g_mem
        localparam int LATG = lat_of(g);
        localparam int BWG  = bw_of(g);
        assign mval[g] = pv[g][LATG-1];
        assign mrd[g]  = pat[g] + ((pa[g][LATG-1] >> 1) & 16'(BWG - 1));
    end

    int errors = 0;
    int checks = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the acceptance cycle k; walks k+1..k+BW+L+1.
    task automatic check_fill(input int n, input logic is_d, input logic [15:0] base,
                              input int drop_at);
        int bw, l;
        logic e_en, e_ret, e_tag, e_done;
        bw = bw_of(n);
        l  = lat_of(n);
        for (int t = 1; t <= bw + l + 1; t++) begin
            @(negedge clk);
            e_en   = (t <= bw);
            e_ret  = (t >= l + 1) && (t <= bw + l);
            e_tag  = (t == bw + l);
            e_done = (t == bw + l + 1);
            chk1("mem_en", men[n], e_en);
            if (e_en) begin
                chk1("mem_wr", mwr[n], 1'b0);
                chk16("mem_addr", maddr[n], base + 16'(2 * (t - 1)));
            end
            chk1("fill_we_i", fwi[n], e_ret && !is_d);
            chk1("fill_we_d", fwd[n], e_ret && is_d);
            if (e_ret) begin
                chk16("fill_idx", fidx[n], 16'(t - 1 - l));
                chk16("fill_data", fdat[n], pat[n] + 16'(t - 1 - l));
            end
            chk1("tag_we_i", twi[n], e_tag && !is_d);
            chk1("tag_we_d", twd[n], e_tag && is_d);
            chk1("i_done", idn[n], e_done && !is_d);
            chk1("d_done", ddn[n], e_done && is_d);
            chk16("fill_base", fbase[n], base);
            chk1("busy", bsy[n], 1'b1);
            chk1("i_stall", ist[n], im[n] && !(e_done && !is_d));
            chk1("d_stall", dst[n], (dm[n] || dw[n]) && !(e_done && is_d));
            if (t == drop_at) begin
                if (is_d) dm[n] = 1'b0;
                else      im[n] = 1'b0;
            end
        end
    endtask

    // Called at the negedge of the acceptance cycle k of a store.
    task automatic check_store(input int n, input logic [15:0] a, input logic [15:0] wd);
        @(negedge clk);
        chk1("st_mem_en", men[n], 1'b1);
        chk1("st_mem_wr", mwr[n], 1'b1);
        chk16("st_mem_addr", maddr[n], a);
        chk16("st_mem_wdata", mwd[n], wd);
        chk1("st_d_done_early", ddn[n], 1'b0);
        chk1("st_i_stall", ist[n], im[n]);
        @(negedge clk);
        chk1("st_mem_en_after", men[n], 1'b0);
        chk1("st_d_done", ddn[n], 1'b1);
        chk1("st_d_stall", dst[n], 1'b0);
        chk1("st_busy", bsy[n], 1'b1);
    endtask

    task automatic idle_gap(input int n);
        @(negedge clk);
        chk1("gap_busy", bsy[n], 1'b0);
        chk1("gap_mem_en", men[n], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] b, a, wd;
        int kind;
        for (int n = 0; n < N; n++) begin
            im[n] = 1'b0; dm[n] = 1'b0; dw[n] = 1'b0;
            iaddr[n] = '0; daddr[n] = '0; dwd[n] = '0; pat[n] = '0;
        end

        // Reset held with an I-miss already pending.
        im[0] = 1'b1; iaddr[0] = 16'h1236; pat[0] = 16'hA000;
        repeat (3) begin
            @(negedge clk);
            chk1("rst_busy", bsy[0], 1'b1);
            chk1("rst_mem_en", men[0], 1'b0);
            chk1("rst_i_stall", ist[0], 1'b0);
            chk1("rst_fill_we_i", fwi[0], 1'b0);
            chk1("rst_i_done", idn[0], 1'b0);
            chk16("rst_fill_base", fbase[0], 16'h0000);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("drain_mem_en", men[0], 1'b0);
            chk1("drain_busy", bsy[0], 1'b1);
            chk1("drain_i_stall", ist[0], 1'b1);
        end
        @(negedge clk);
        chk1("drain_last_mem_en", men[0], 1'b0);
        check_fill(0, 1'b0, 16'h1230, 0);
        im[0] = 1'b0;

        // Store, D-miss and I-miss raised together.
        idle_gap(0);
        dw[0] = 1'b1; dm[0] = 1'b1; im[0] = 1'b1;
        daddr[0] = 16'h0040; dwd[0] = 16'hBEEF;
        iaddr[0] = 16'($urandom);
        #1;
        chk1("raise_i_stall", ist[0], 1'b1);
        chk1("raise_d_stall", dst[0], 1'b1);
        check_store(0, 16'h0040, 16'hBEEF);
        dw[0] = 1'b0;
        daddr[0] = 16'($urandom);
        pat[0] = 16'($urandom);
        @(negedge clk);
        check_fill(0, 1'b1, blk_base(0, daddr[0]), 0);
        dm[0] = 1'b0;
        pat[0] = 16'($urandom);
        @(negedge clk);
        check_fill(0, 1'b0, blk_base(0, iaddr[0]), 0);
        im[0] = 1'b0;

        // I-miss dropped two cycles into the fill.
        idle_gap(0);
        im[0] = 1'b1; iaddr[0] = 16'($urandom); pat[0] = 16'($urandom);
        check_fill(0, 1'b0, blk_base(0, iaddr[0]), 2);
        im[0] = 1'b0;

        // Random mix of transactions.
        for (int r = 0; r < 6; r++) begin
            idle_gap(0);
            kind = int'($urandom_range(0, 2));
            pat[0] = 16'($urandom);
            if (kind == 0) begin
                a  = 16'($urandom) & 16'hFFFE;
                wd = 16'($urandom);
                dw[0] = 1'b1; daddr[0] = a; dwd[0] = wd;
                check_store(0, a, wd);
                dw[0] = 1'b0;
            end else if (kind == 1) begin
                dm[0] = 1'b1; daddr[0] = 16'($urandom);
                check_fill(0, 1'b1, blk_base(0, daddr[0]), 0);
                dm[0] = 1'b0;
            end else begin
                im[0] = 1'b1; iaddr[0] = 16'($urandom);
                check_fill(0, 1'b0, blk_base(0, iaddr[0]), 0);
                im[0] = 1'b0;
            end
        end

        // Reset after three returns of an I-fill, then a D-miss after the drain.
        idle_gap(0);
        im[0] = 1'b1; iaddr[0] = 16'($urandom); pat[0] = 16'($urandom);
        b = blk_base(0, iaddr[0]);
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            chk1("mid_mem_en", men[0], 1'b1);
            chk16("mid_mem_addr", maddr[0], b + 16'(2 * (t - 1)));
            chk1("mid_fill_we_i", fwi[0], t >= 5);
            if (t >= 5) chk16("mid_fill_idx", fidx[0], 16'(t - 5));
            chk1("mid_tag_we_i", twi[0], 1'b0);
        end
        rst = 1'b0; im[0] = 1'b0;
        @(negedge clk);
        chk1("mid_rst_fill_we_i", fwi[0], 1'b0);
        chk1("mid_rst_tag_we_i", twi[0], 1'b0);
        chk1("mid_rst_busy", bsy[0], 1'b1);
        rst = 1'b1;
        dm[0] = 1'b1; daddr[0] = 16'($urandom); pat[0] = 16'($urandom);
        repeat (3) begin
            @(negedge clk);
            chk1("stale_fill_we_i", fwi[0], 1'b0);
            chk1("stale_fill_we_d", fwd[0], 1'b0);
            chk1("stale_tag_we_i", twi[0], 1'b0);
            chk1("stale_tag_we_d", twd[0], 1'b0);
            chk1("stale_mem_en", men[0], 1'b0);
            chk1("stale_busy", bsy[0], 1'b1);
            chk1("stale_d_stall", dst[0], 1'b1);
        end
        @(negedge clk);
        chk1("stale_last_mem_en", men[0], 1'b0);
        check_fill(0, 1'b1, blk_base(0, daddr[0]), 0);
        dm[0] = 1'b0;

        // Geometry sweep: small block / short latency, large block / long latency.
        for (int n = 1; n < N; n++) begin
            repeat (2) idle_gap(n);
            im[n] = 1'b1; iaddr[n] = 16'($urandom); pat[n] = 16'($urandom);
            check_fill(n, 1'b0, blk_base(n, iaddr[n]), 0);
            im[n] = 1'b0;
            idle_gap(n);
            dm[n] = 1'b1; daddr[n] = 16'($urandom); pat[n] = 16'($urandom);
            check_fill(n, 1'b1, blk_base(n, daddr[n]), 0);
            dm[n] = 1'b0;
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Parametrised miss-handling engine shared by the instruction and data caches of the pipelined CPU. It arbitrates I-cache misses, D-cache misses and D-cache write-through stores onto a single pipelined, fixed-latency main-memory port. It streams block fills back into the requesting cache and produces per-cache stall and completion signals. It replaces the fixed-geometry, single-outstanding-word fill logic with configurable block size, memory latency and pipelined word requests.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, memory/cache word width
- WORD_BYTES, 2, bytes per word; power of 2
- BLOCK_WORDS, 8, words per cache block; power of 2, ≥2
- MEM_LATENCY, 4, cycles from mem_en to mem_valid; ≥1
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- i_miss  in  1  I-cache miss request, held until i_done
- i_miss_addr  in  ADDR_W  I-cache miss byte address
- d_miss  in  1  D-cache read-miss request, held until d_done
- d_wr  in  1  D-cache write-through store request, held until d_done
- d_addr  in  ADDR_W  D-side address (miss or store)
- d_wdata  in  DATA_W  store data
- mem_en, mem_wr  out  1  memory request strobe / write qualifier
- mem_addr  out  ADDR_W  memory word address (byte-aligned to WORD_BYTES)
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid with mem_valid
- mem_valid  in  1  read-return strobe
- fill_we_i, fill_we_d  out  1  data-array write enable for I- or D-cache
- fill_idx  out  log2(BLOCK_WORDS)  word index within block
- fill_data  out  DATA_W  word being filled
- fill_base  out  ADDR_W  block-aligned base address of current fill
- tag_we_i, tag_we_d  out  1  one-cycle tag/valid write pulse
- i_done, d_done  out  1  one-cycle completion pulse
- i_stall, d_stall  out  1  stall to IF and MEM stages
- busy  out  1  FSM not in IDLE, or post-reset drain in progress

## Operation
- States: IDLE, FILL_I, FILL_D, WRITE, DONE_I, DONE_D.
- IDLE priority when drain counter is 0: d_wr > d_miss > i_miss. Store misses do not allocate (write-through, no-write-allocate).
- Requests are sampled only in IDLE. Once accepted, a transaction always completes, even if the request drops.
- FILL_x: fill_base = addr & ~(BLOCK_WORDS*WORD_BYTES-1). Issue counter iss runs 0..BLOCK_WORDS-1. mem_en=1, mem_wr=0, mem_addr = fill_base + iss*WORD_BYTES, one request per cycle, no gaps.
- Return counter ret counts mem_valid strobes. Each strobe drives fill_we_x=1, fill_idx=ret, fill_data=mem_rdata, combinationally in the same cycle.
- The return with ret==BLOCK_WORDS-1 also pulses tag_we_x, and the FSM goes to DONE_x.
- WRITE: a single cycle with mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, then DONE_D.
- DONE_x: pulse x_done for one cycle, then IDLE.
- mem_valid is ignored outside FILL_x, and ignored once ret==BLOCK_WORDS.
- i_stall = i_miss & ~i_done. d_stall = (d_miss | d_wr) & ~d_done. These are combinational, so a request stalls in the cycle it is raised.
- Address arithmetic is modulo 2^ADDR_W. A block never crosses the top of the address space because it is aligned.

## Timing
- Reset (rst=0 at an edge): state=IDLE, iss=ret=0, and every registered output is 0. While rst is held, all outputs are 0 except busy=1.
- Drain counter loads MEM_LATENCY at reset and decrements each cycle after rst rises. Requests are not accepted until it reaches 0. This prevents stale returns from a fill aborted by reset from being captured.
- Reset mid-fill: the fill is abandoned, no tag_we is issued, and the cache line stays invalid.
- Fill accepted in cycle k (IDLE, request high):
  - mem_en in cycles k+1 .. k+BLOCK_WORDS.
  - Returns in cycles k+1+MEM_LATENCY .. k+BLOCK_WORDS+MEM_LATENCY.
  - tag_we in the last return cycle.
  - done in cycle k+BLOCK_WORDS+MEM_LATENCY+1.
- Store accepted in cycle k: mem write in cycle k+1, d_done in cycle k+2.
- The earliest next acceptance is the cycle after DONE, so back-to-back transactions have one IDLE cycle between them.
- With defaults, fill latency from acceptance to done is 13 cycles.

## Test plan
- Reset drain: release rst with i_miss=1 already high -> no mem_en for 4 cycles; FILL_I begins when the counter reaches 0; busy=1 throughout.
- I-fill, i_miss_addr=0x1236: mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles. Memory returns 0xA000+idx -> fill_we_i with idx 0..7 and matching data; tag_we_i on the 8th return; i_done at k+13; i_stall low in the same cycle.
- Simultaneous d_wr (0x0040, 0xBEEF), d_miss and i_miss in one cycle -> WRITE first (mem_wr=1, addr 0x0040, data 0xBEEF), d_done at k+2. Then the D-fill, then the I-fill. i_stall stays high until its own i_done.
- Request dropped: i_miss deasserted 2 cycles into a fill -> all 8 words still issued and returned, tag_we_i pulses, i_done pulses.
- Reset mid-fill after 3 returns -> tag_we never pulses. Stale mem_valid strobes during the 4-cycle drain produce no fill_we. A subsequent d_miss fills correctly.
- Parameter sweep: BLOCK_WORDS=2/MEM_LATENCY=1 and BLOCK_WORDS=16/MEM_LATENCY=7 -> done at k+4 and k+24 respectively; fill_idx wraps correctly at block end.
